// File: rtl/bus_datapath_slave.sv
// Bus responder holding the four general registers, the RAM address register and a RAM.
// Obeys the sequencer's load/drive strobes and flags illegal strobe combinations.
module bus_datapath_slave #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idr_0,
   input  logic             idr_bp,
   input  logic             idr_sp,
   input  logic             idr_1,
   input  logic             edr_0,
   input  logic             edr_bp,
   input  logic             edr_sp,
   input  logic             edr_1,
   input  logic             iaddr,
   input  logic             iram,
   input  logic             eram,
   input  logic             ext_drive,
   input  logic [WIDTH-1:0] bus_in,
   output logic [WIDTH-1:0] bus_out,
   output logic             bus_oe,
   output logic [WIDTH-1:0] r0_q,
   output logic [WIDTH-1:0] bp_q,
   output logic [WIDTH-1:0] sp_q,
   output logic [WIDTH-1:0] r1_q,
   output logic [AW-1:0]    addr_q,
   output logic             bus_err
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [2:0]       n_drv;
   logic [WIDTH-1:0] rb_d;
   logic             err_d;

   assign n_drv = 3'(edr_0) + 3'(edr_bp) + 3'(edr_sp) + 3'(edr_1) + 3'(eram);
   assign bus_oe = (n_drv != 3'd0);

   // Only a single driver puts data on the bus; contention yields 0.
   always_comb begin
      bus_out = '0;
      if (n_drv == 3'd1) begin
         if (edr_0)       bus_out = r0_q;
         else if (edr_bp) bus_out = bp_q;
         else if (edr_sp) bus_out = sp_q;
         else if (edr_1)  bus_out = r1_q;
         else             bus_out = mem[addr_q];
      end
   end

   always_comb begin
      rb_d = '0;
      if (bus_oe)         rb_d = bus_out;
      else if (ext_drive) rb_d = bus_in;
   end

   assign err_d = (n_drv > 3'd1) | (bus_oe & ext_drive) | (eram & iram) | (eram & iaddr)
                | (iram & iaddr);

   always_ff @(posedge clk) begin
      if (reset) begin
         r0_q    <= '0;
         bp_q    <= '0;
         sp_q    <= '0;
         r1_q    <= '0;
         addr_q  <= '0;
         bus_err <= 1'b0;
      end else if (err_d) begin
         bus_err <= 1'b1;
      end else begin
         if (idr_0)  r0_q   <= rb_d;
         if (idr_bp) bp_q   <= rb_d;
         if (idr_sp) sp_q   <= rb_d;
         if (idr_1)  r1_q   <= rb_d;
         if (iaddr)  addr_q <= rb_d[AW-1:0];
      end
   end

   // RAM is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (!reset && !err_d && iram) mem[addr_q] <= rb_d;
   end

endmodule
